multi_tick_sink: RTL and testbench

MULTI_TICK_SINK -- requirements
Module: multi_tick_sink

---
 rtl/multi_tick_sink.sv | 88 ++++++++
 tb/tb_multi_tick_sink.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_sink.sv
// Beat-accumulating sink: collects SAMPLES unsigned 8-bit beats, then holds their
// sum and maximum until the downstream consumer takes the result.
module multi_tick_sink #(
    parameter int SAMPLES = 4
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [11:0] out_sum,
    output logic [7:0]  out_max
);

    // state | meaning
    // ACCUM | accepting beats, accumulating sum/max
    // HOLD  | result presented, waiting for out_ready
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam logic [4:0] LAST_CNT = 5'(SAMPLES);

    logic [0:0]  r_state;
    logic [11:0] r_sum;
    logic [7:0]  r_max;
    logic [4:0]  r_cnt;

    logic        w_accept;
    logic        w_consume;
    logic        w_last_beat;
    logic [4:0]  w_cnt_inc;

    assign w_accept    = in_valid && (r_state == ACCUM);
    assign w_consume   = out_ready && (r_state == HOLD);
    assign w_cnt_inc   = r_cnt + 5'd1;
    assign w_last_beat = w_accept && (w_cnt_inc == LAST_CNT);

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign out_sum   = r_sum;
    assign out_max   = r_max;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_last_beat) r_state <= HOLD;
                HOLD:    if (w_consume)   r_state <= ACCUM;
                default: r_state <= ACCUM;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 5'd0;
        end else if (w_consume) begin
            r_cnt <= 5'd0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Sum and max tick independently; each only looks at its own register and the beat.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= 12'd0;
        end else if (w_consume) begin
            r_sum <= 12'd0;
        end else if (w_accept) begin
            r_sum <= r_sum + {4'd0, in_data};
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= 8'd0;
        end else if (w_consume) begin
            r_max <= 8'd0;
        end else if (w_accept && (in_data > r_max)) begin
            r_max <= in_data;
        end
    end

endmodule

// File: tb/tb_multi_tick_sink.sv
// Directed bench for multi_tick_sink with SAMPLES = 4, 16 and 1 instances sharing
// clock and reset; expected results are queued when beats are driven.
module tb_multi_tick_sink;

    logic        clock;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [7:0]  in_data [3];
    logic [11:0] out_sum [3];
    logic [7:0]  out_max [3];

    typedef struct {
        logic [11:0] sum;
        logic [7:0]  max;
    } res_t;

    res_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    multi_tick_sink #(.SAMPLES(4)) u_dut4 (
        .clock(clock), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
        .out_ready(out_ready[0]), .out_valid(out_valid[0]),
        .out_sum(out_sum[0]), .out_max(out_max[0])
    );

    multi_tick_sink #(.SAMPLES(16)) u_dut16 (
        .clock(clock), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
        .out_ready(out_ready[1]), .out_valid(out_valid[1]),
        .out_sum(out_sum[1]), .out_max(out_max[1])
    );

    multi_tick_sink #(.SAMPLES(1)) u_dut1 (
        .clock(clock), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
        .out_ready(out_ready[2]), .out_valid(out_valid[2]),
        .out_sum(out_sum[2]), .out_max(out_max[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] data);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        tick();
        in_valid[d] = 1'b0;
    endtask

    task automatic expect_res(input logic [11:0] s, input logic [7:0] m);
        res_t r;
        r.sum = s;
        r.max = m;
        sb.push_back(r);
    endtask

    task automatic check_out(input int d, input string tag);
        res_t e;
        chk({tag, "_valid"}, 32'(out_valid[d]), 32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready[d]), 32'd0);
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s_sb: observed=result expected=none queued", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(out_sum[d]), 32'(e.sum));
            chk({tag, "_max"}, 32'(out_max[d]), 32'(e.max));
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        chk({tag, "_valid"}, 32'(out_valid[d]), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready[d]), 32'd1);
    endtask

    // Waits a bounded number of cycles for a result on instance d.
    task automatic wait_out(input int d, input string tag);
        int n;
        n = 0;
        while (!out_valid[d] && n < 40) begin
            tick();
            n++;
        end
        check_out(d, tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 3'b000;
        out_ready = 3'b111;
        for (int i = 0; i < 3; i++) in_data[i] = 8'd0;

        #2;
        for (int i = 0; i < 3; i++) begin
            check_idle(i, $sformatf("rst%0d", i));
            chk($sformatf("rst%0d_sum", i), 32'(out_sum[i]), 32'd0);
            chk($sformatf("rst%0d_max", i), 32'(out_max[i]), 32'd0);
        end
        tick();
        rst_n = 1'b1;

        // basic: 10,20,30,40 back to back, result for exactly one cycle
        expect_res(12'd100, 8'd40);
        send(0, 8'd10);
        send(0, 8'd20);
        send(0, 8'd30);
        check_idle(0, "basic_pre");
        send(0, 8'd40);
        check_out(0, "basic");
        tick();
        check_idle(0, "basic_post");

        // backpressure: held for 6 cycles; beats offered in HOLD are ignored
        out_ready[0] = 1'b0;
        expect_res(12'd100, 8'd40);
        send(0, 8'd10);
        send(0, 8'd20);
        send(0, 8'd30);
        send(0, 8'd40);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid%0d", i), 32'(out_valid[0]), 32'd1);
            chk($sformatf("bp_in_ready%0d", i), 32'(in_ready[0]), 32'd0);
            chk($sformatf("bp_sum%0d", i), 32'(out_sum[0]), 32'd100);
            chk($sformatf("bp_max%0d", i), 32'(out_max[0]), 32'd40);
            in_valid[0] = 1'b1;
            in_data[0]  = 8'd99;
            tick();
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        check_out(0, "bp_last");
        tick();
        check_idle(0, "bp_post");

        // gaps and max ordering
        expect_res(12'd411, 8'd200);
        send(0, 8'd200);
        tick();
        tick();
        send(0, 8'd5);
        tick();
        send(0, 8'd7);
        check_idle(0, "gap_pre");
        send(0, 8'd199);
        wait_out(0, "gap");
        tick();
        check_idle(0, "gap_post");

        // reset in the middle of accumulation
        send(0, 8'd1);
        send(0, 8'd2);
        rst_n = 1'b0;
        #1;
        check_idle(0, "mid_rst");
        chk("mid_rst_sum", 32'(out_sum[0]), 32'd0);
        chk("mid_rst_max", 32'(out_max[0]), 32'd0);
        tick();
        check_idle(0, "mid_rst_edge");
        rst_n = 1'b1;
        expect_res(12'd18, 8'd6);
        send(0, 8'd3);
        send(0, 8'd4);
        send(0, 8'd5);
        check_idle(0, "rst_acc_pre");
        send(0, 8'd6);
        check_out(0, "rst_acc");
        tick();
        check_idle(0, "rst_acc_post");

        // width bound on the SAMPLES=16 instance
        expect_res(12'd4080, 8'd255);
        for (int i = 0; i < 15; i++) send(1, 8'd255);
        check_idle(1, "wide_pre");
        send(1, 8'd255);
        check_out(1, "wide");
        tick();
        check_idle(1, "wide_post");

        // SAMPLES=1: every beat is a result
        expect_res(12'd9, 8'd9);
        send(2, 8'd9);
        check_out(2, "one_a");
        tick();
        check_idle(2, "one_gap");
        expect_res(12'd3, 8'd3);
        send(2, 8'd3);
        check_out(2, "one_b");
        tick();
        check_idle(2, "one_post");

        n_chk++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_empty: observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
